// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and the
// helper that sizes the bit counter.
package adder_pkg;

    typedef logic [1:0] adder_state_t;

    localparam adder_state_t IDLE  = 2'd0;
    localparam adder_state_t SHIFT = 2'd1;
    localparam adder_state_t DONE  = 2'd2;

    // Bit counter width: enough to count 0..width-1, never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell: the only arithmetic in the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: streams WIDTH operand bit pairs, LSB first, through one
// full-adder cell with a registered carry. The result appears on sum/cout
// together with a one-cycle done pulse WIDTH cycles after start is accepted.
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    adder_state_t     state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST_CNT);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    // Partial sum after this bit: new sum bit enters at the MSB as the register shifts right.
    always_comb begin
        sum_next            = sum_sr >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    // Control FSM: IDLE accepts start, SHIFT runs WIDTH bits, DONE lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= SHIFT;
                SHIFT:   if (last_bit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/partial-sum shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            sum_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_next;
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result registers: only the final bit's edge updates them, so no partial result is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            sum  <= sum_next;
            cout <= fa_cout;
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: directed scenarios on a WIDTH=8 instance and a
// randomized back-to-back run on WIDTH=8 and WIDTH=1 instances against an
// arithmetic a+b+cin model with the documented accept/complete schedule.
module tb_bit_serial_adder;

    localparam int W  = 8;
    localparam int W1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          cin   = 1'b0;
    logic          busy, done, cout;
    logic [W-1:0]  sum;

    logic          start1 = 1'b0;
    logic [W1-1:0] a1     = '0;
    logic [W1-1:0] b1     = '0;
    logic          cin1   = 1'b0;
    logic          busy1, done1, cout1;
    logic [W1-1:0] sum1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    bit_serial_adder #(.WIDTH(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Stimulus only: one start pulse, then observe the W=8 instance for W+4 samples after the accepting edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output int done_at, output int nbusy, output int ndone);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        done_at = -1; nbusy = 0; ndone = 0;
        for (int k = 0; k <= W + 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        start = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        start1 = 1'($urandom); a1 = W1'($urandom); b1 = W1'($urandom); cin1 = 1'($urandom);
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (sum !== '0) begin miscompares++; $display("FAIL reset_sum: got %h want 00", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b want 0", cout); end
        vectors++; if ({busy1, done1, sum1, cout1} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_w1: got %b want 0000", {busy1, done1, sum1, cout1});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int done_at, nbusy, ndone;
        run_op(8'hFF, 8'h01, 1'b0, done_at, nbusy, ndone);
        vectors++; if (done_at !== W) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", done_at, W); end
        vectors++; if (nbusy !== W) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want %0d", nbusy, W); end
        vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d want 1", ndone); end
        vectors++; if (sum !== 8'h00) begin miscompares++; $display("FAIL basic_sum: got %h want 00", sum); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("FAIL basic_cout: got %b want 1", cout); end
    endtask

    task automatic test_hold();
        int done_at, nbusy, ndone;
        run_op(8'h3C, 8'h42, 1'b1, done_at, nbusy, ndone);
        vectors++; if (done_at !== W) begin miscompares++; $display("FAIL hold_latency: got %0d want %0d", done_at, W); end
        vectors++; if (sum !== 8'h7F) begin miscompares++; $display("FAIL hold_sum: got %h want 7f", sum); end
        vectors++; if (cout !== 1'b0) begin miscompares++; $display("FAIL hold_cout: got %b want 0", cout); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            vectors++; if (sum !== 8'h7F || cout !== 1'b0) begin
                miscompares++; $display("FAIL hold_stable: cycle %0d got %h/%b want 7f/0", k, sum, cout);
            end
        end
    endtask

    task automatic test_ignore();
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int k = 0; k <= W + 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            if (k == 5) start = 1'b0;
            if (k < W) begin
                vectors++; if (done !== 1'b0 || sum !== 8'h7F || cout !== 1'b0) begin
                    miscompares++; $display("FAIL ignore_midrun: k=%0d got done=%b sum=%h cout=%b want 0/7f/0", k, done, sum, cout);
                end
            end else if (k == W) begin
                vectors++; if (done !== 1'b1 || sum !== 8'h30 || cout !== 1'b0) begin
                    miscompares++; $display("FAIL ignore_result: got done=%b sum=%h cout=%b want 1/30/0", done, sum, cout);
                end
            end else begin
                vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
                    miscompares++; $display("FAIL ignore_after: k=%0d got done=%b busy=%b want 0 0", k, done, busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_at, nbusy, ndone;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        vectors++; if (sum !== '0 || cout !== 1'b0) begin
            miscompares++; $display("FAIL midreset_result: got %h/%b want 00/0", sum, cout);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL midreset_quiet: k=%0d got done=%b busy=%b want 0 0", k, done, busy);
            end
        end
        run_op(8'hFF, 8'hFF, 1'b1, done_at, nbusy, ndone);
        vectors++; if (done_at !== W) begin miscompares++; $display("FAIL postreset_latency: got %0d want %0d", done_at, W); end
        vectors++; if (sum !== 8'hFF || cout !== 1'b1) begin
            miscompares++; $display("FAIL postreset_result: got %h/%b want ff/1", sum, cout);
        end
    endtask

    // start held high: accepts at edges n*(W+2), completions W edges after each accept.
    task automatic test_back_to_back();
        logic [W:0]  q8[$];
        logic [W1:0] q1[$];
        logic [W:0]  exp8;
        logic [W1:0] exp1;
        for (int c = 0; c < 1000 * (W + 2); c++) begin
            @(negedge clk);
            start = 1'b1; start1 = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            a1 = W1'($urandom); b1 = W1'($urandom); cin1 = 1'($urandom);
            @(posedge clk);
            if (c % (W + 2) == 0) q8.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(cin));
            if (c % (W1 + 2) == 0) q1.push_back({1'b0, a1} + {1'b0, b1} + (W1 + 1)'(cin1));
            #1;
            if (c % (W + 2) == W) begin
                exp8 = (q8.size() > 0) ? q8.pop_front() : 'x;
                vectors++; if (done !== 1'b1 || {cout, sum} !== exp8) begin
                    miscompares++; $display("FAIL b2b_w8: edge %0d got done=%b {cout,sum}=%h want 1/%h", c, done, {cout, sum}, exp8);
                end
            end else begin
                vectors++; if (done !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_w8_spacing: edge %0d got done=%b want 0", c, done);
                end
            end
            if (c % (W1 + 2) == W1) begin
                exp1 = (q1.size() > 0) ? q1.pop_front() : 'x;
                vectors++; if (done1 !== 1'b1 || {cout1, sum1} !== exp1) begin
                    miscompares++; $display("FAIL b2b_w1: edge %0d got done=%b {cout,sum}=%b want 1/%b", c, done1, {cout1, sum1}, exp1);
                end
            end else begin
                vectors++; if (done1 !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_w1_spacing: edge %0d got done=%b want 0", c, done1);
                end
            end
        end
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
